// File: rtl/coef_pack_2861_if.sv
// Stream bundle for the coefficient packer: a 12-bit coefficient stream in
// and a 32-bit word stream out, both with valid/ready handshakes and
// last-of-packet flags.
interface coef_pack_2861_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_coef;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_last;

  // Side that feeds coefficients and consumes words.
  modport master (
    output in_valid, in_coef, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_last
  );

  // The packer itself.
  modport slave (
    input  in_valid, in_coef, in_last, out_ready,
    output in_ready, out_valid, out_word, out_last
  );
endinterface

// File: rtl/coef_pack_2861.sv
// Packs 12-bit residues mod 2861 LSB-first into 32-bit words. A packet
// ends with in_last; the remaining bits are then flushed as zero-padded
// words, the final one flagged with out_last. Any coefficient >= Q sets a
// sticky range error but is still packed unchanged.
module coef_pack_2861 #(
  parameter int Q      = 2861,
  parameter int COEF_W = 12,
  parameter int WORD_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  coef_pack_2861_if.slave  bus,
  input  logic             clr_err,
  output logic             range_err
);

  localparam int BUF_W = WORD_W + COEF_W;
  localparam logic [COEF_W-1:0] Q_LIM  = COEF_W'(Q);
  localparam logic [5:0]        W_FULL = 6'(WORD_W);
  localparam logic [5:0]        C_STEP = 6'(COEF_W);

  typedef enum logic {ST_FILL, ST_DRAIN} state_t;

  state_t           st_q, st_nxt;
  logic [BUF_W-1:0] shift_buf_q, shift_buf_nxt;
  logic [5:0]       fill_q, fill_nxt;
  logic             accept, pop;

  // Handshake decode and next-state for the buffer, fill count and state.
  always_comb begin
    shift_buf_nxt = shift_buf_q;
    fill_nxt      = fill_q;
    st_nxt        = st_q;

    bus.in_ready  = (st_q == ST_FILL) && (fill_q < W_FULL);
    bus.out_valid = (st_q == ST_FILL) ? (fill_q >= W_FULL) : (fill_q != 6'd0);
    bus.out_last  = (st_q == ST_DRAIN) && (fill_q <= W_FULL);
    bus.out_word  = shift_buf_q[WORD_W-1:0];

    accept = bus.in_valid && bus.in_ready;
    pop    = bus.out_valid && bus.out_ready;

    if (accept) begin
      shift_buf_nxt = shift_buf_q | (BUF_W'(bus.in_coef) << fill_q);
      fill_nxt      = fill_q + C_STEP;
      if (bus.in_last) begin
        st_nxt = ST_DRAIN;
      end
    end else if (pop) begin
      if (bus.out_last) begin
        shift_buf_nxt = '0;
        fill_nxt      = 6'd0;
        st_nxt        = ST_FILL;
      end else begin
        shift_buf_nxt = shift_buf_q >> WORD_W;
        fill_nxt      = (fill_q >= W_FULL) ? (fill_q - W_FULL) : 6'd0;
      end
    end
  end

  // State registers; reset discards any partially packed data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_FILL;
      shift_buf_q <= '0;
      fill_q      <= 6'd0;
    end else begin
      st_q        <= st_nxt;
      shift_buf_q <= shift_buf_nxt;
      fill_q      <= fill_nxt;
    end
  end

  // Sticky range flag: an out-of-range accept wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err <= 1'b0;
    end else if (accept && (bus.in_coef >= Q_LIM)) begin
      range_err <= 1'b1;
    end else if (clr_err) begin
      range_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coef_pack_2861.sv
// Directed bench for coef_pack_2861: hand-computed words for several
// packets, range-error set/clear priority, backpressure and mid-packet reset.
module tb_coef_pack_2861;

  logic clk;
  logic rst_n;
  logic clr_err;
  logic range_err;
  int   total;
  int   bad;

  coef_pack_2861_if bus ();

  coef_pack_2861 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .clr_err   (clr_err),
    .range_err (range_err)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  // Offer one coefficient and hold it until accepted (bounded wait).
  task automatic applyStimulus(input logic [11:0] coef, input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_coef  = coef;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait for a word, check it, then pop it.
  task automatic popWord(input string tag, input logic [31:0] exp_word, input logic exp_last);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    checkOutput({tag, "_word"}, bus.out_word, exp_word);
    checkOutput({tag, "_last"}, {31'd0, bus.out_last}, {31'd0, exp_last});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic sendAbcPacket(input string tag);
    for (int i = 0; i < 3; i++) applyStimulus(12'hABC, 1'b0);
    popWord({tag, "_w0"}, 32'hBCABCABC, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(12'hABC, 1'b0);
    popWord({tag, "_w1"}, 32'hCABCABCA, 1'b0);
    applyStimulus(12'hABC, 1'b0);
    applyStimulus(12'hABC, 1'b1);
    popWord({tag, "_w2"}, 32'hABCABCAB, 1'b1);
    checkOutput({tag, "_idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
    checkOutput({tag, "_idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    clr_err       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_coef   = 12'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #23;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] reset state");
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_word", bus.out_word, 32'd0);
    checkOutput("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    checkOutput("rst_range_err", {31'd0, range_err}, 32'd0);

    $display("[TB] eight 0xABC coefficients");
    sendAbcPacket("abc");
    checkOutput("abc_range_err", {31'd0, range_err}, 32'd0);

    $display("[TB] single coefficient packet");
    applyStimulus(12'h7FF, 1'b1);
    checkOutput("one_valid_next", {31'd0, bus.out_valid}, 32'd1);
    popWord("one", 32'h000007FF, 1'b1);
    checkOutput("one_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("one_out_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("[TB] three coefficient packet with spill");
    applyStimulus(12'h001, 1'b0);
    applyStimulus(12'h002, 1'b0);
    applyStimulus(12'h003, 1'b1);
    popWord("three_w0", 32'h03002001, 1'b0);
    popWord("three_w1", 32'h00000000, 1'b1);

    $display("[TB] range error set and clear");
    applyStimulus(12'hB2D, 1'b1);
    checkOutput("rerr_set", {31'd0, range_err}, 32'd1);
    popWord("rerr_w", 32'h00000B2D, 1'b1);
    clr_err = 1'b1;
    applyStimulus(12'hB54, 1'b1);
    clr_err = 1'b0;
    checkOutput("rerr_set_wins", {31'd0, range_err}, 32'd1);
    popWord("rerr_w2", 32'h00000B54, 1'b1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    checkOutput("rerr_cleared", {31'd0, range_err}, 32'd0);

    $display("[TB] backpressure");
    applyStimulus(12'h001, 1'b0);
    applyStimulus(12'h002, 1'b0);
    applyStimulus(12'h003, 1'b0);
    held = bus.out_word;
    checkOutput("bp_first_word", held, 32'h03002001);
    bus.in_valid = 1'b1;
    bus.in_coef  = 12'h004;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_stable_word", bus.out_word, 32'h03002001);
      checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      checkOutput("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    popWord("bp_w0", 32'h03002001, 1'b0);
    applyStimulus(12'h004, 1'b0);
    applyStimulus(12'h005, 1'b0);
    applyStimulus(12'h006, 1'b0);
    popWord("bp_w1", 32'h60050040, 1'b0);
    applyStimulus(12'h007, 1'b0);
    applyStimulus(12'h008, 1'b1);
    popWord("bp_w2", 32'h00800700, 1'b1);

    $display("[TB] reset mid packet");
    applyStimulus(12'hABC, 1'b0);
    applyStimulus(12'hFFF, 1'b0);
    applyStimulus(12'hABC, 1'b0);
    checkOutput("mid_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("mid_pre_rerr", {31'd0, range_err}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("mid_rst_rerr", {31'd0, range_err}, 32'd0);
    checkOutput("mid_rst_word", bus.out_word, 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_after_valid", {31'd0, bus.out_valid}, 32'd0);
    sendAbcPacket("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
